// File: rtl/qupls_miss_sequencer_pkg.sv
// Shared types for branch-miss recovery: recovery state encoding, extended PC
// and reset constants.
package qupls_miss_sequencer_pkg;

   // Stomp logic decodes CHKPT_RESTORE..DONE2 as a range, so keep this order.
   typedef enum logic [2:0] {
      BS_IDLE,
      BS_CHKPT_RESTORE,
      BS_CHKPT_RESTORED,
      BS_CAPTURE_MISSPC,
      BS_DONE,
      BS_DONE2
   } branch_state_t;

   typedef struct packed {
      logic [2:0]  bno_t;
      logic [2:0]  bno_f;
      logic [31:0] pc;
   } pc_address_ex_t;

   localparam logic [31:0]    RSTPC      = 32'hFFFC_0100;
   localparam int             MISS_TMO   = 63;
   localparam pc_address_ex_t RST_MISSPC = '{bno_t: 3'd1, bno_f: 3'd0, pc: RSTPC};

endpackage

// File: rtl/qupls_miss_sequencer_if.sv
// Miss-report bus from the flow-control units plus the checkpoint restore
// handshake; the sequencer sits on the slave side.
interface qupls_miss_sequencer_if
   import qupls_miss_sequencer_pkg::*;
#(
   parameter int NREQ  = 2,
   parameter int AGE_W = 8,
   parameter int CP_W  = 4
);
   logic [NREQ-1:0]             miss_req;
   logic [NREQ-1:0][AGE_W-1:0]  miss_age;
   logic [NREQ-1:0][CP_W-1:0]   miss_cp;
   pc_address_ex_t [NREQ-1:0]   miss_pc;
   logic                        restore_req;
   logic [CP_W-1:0]             restore_cp;
   logic                        restore_ack;

   modport master (
      output miss_req, miss_age, miss_cp, miss_pc, restore_ack,
      input  restore_req, restore_cp
   );

   modport slave (
      input  miss_req, miss_age, miss_cp, miss_pc, restore_ack,
      output restore_req, restore_cp
   );
endinterface

// File: rtl/qupls_age_arbiter.sv
// Combinational oldest-age picker over NREQ requesters. Ages are modular
// sequence numbers; equal ages resolve to the lower index.
module qupls_age_arbiter #(
   parameter int NREQ  = 2,
   parameter int AGE_W = 8
) (
   input  logic [NREQ-1:0]            req,
   input  logic [NREQ-1:0][AGE_W-1:0] age,
   output logic                       valid,
   output logic [NREQ-1:0]            grant
);

   logic [AGE_W-1:0] best;
   logic [AGE_W-1:0] diff;

   // Strictly-older test (sign of the modular difference) keeps the earlier
   // index on a tie.
   always_comb begin
      valid = 1'b0;
      grant = '0;
      best  = '0;
      diff  = '0;
      for (int i = 0; i < NREQ; i++) begin
         diff = age[i] - best;
         if (req[i] && (!valid || diff[AGE_W-1])) begin
            valid    = 1'b1;
            grant    = '0;
            grant[i] = 1'b1;
            best     = age[i];
         end
      end
   end

endmodule

// File: rtl/qupls_miss_sequencer.sv
// Branch-miss recovery sequencer: honours the oldest outstanding miss, restores
// its checkpoint, captures the restart PC and lets the pipeline settle.
module qupls_miss_sequencer
   import qupls_miss_sequencer_pkg::*;
#(
   parameter int NREQ  = 2,
   parameter int AGE_W = 8,
   parameter int CP_W  = 4,
   parameter int TMO   = MISS_TMO
) (
   input  logic                  clk,
   input  logic                  rst,
   qupls_miss_sequencer_if.slave bus,
   output logic                  branchmiss,
   output branch_state_t         branch_state,
   output pc_address_ex_t        misspc,
   output logic [AGE_W-1:0]      miss_age_o,
   output logic                  busy,
   output logic                  tmo_err
);

   localparam logic [5:0] TMO_L = 6'(TMO);

   branch_state_t    state, state_nx;
   logic [AGE_W-1:0] age_q;
   logic [CP_W-1:0]  cp_q;
   pc_address_ex_t   pc_q;
   logic [5:0]       wdog;

   logic             win_valid;
   logic [NREQ-1:0]  grant;
   logic [AGE_W-1:0] win_age;
   logic [CP_W-1:0]  win_cp;
   pc_address_ex_t   win_pc;
   logic [AGE_W-1:0] age_diff;
   logic             take;
   logic             expire;

   qupls_age_arbiter #(.NREQ(NREQ), .AGE_W(AGE_W)) u_arb (
      .req   (bus.miss_req),
      .age   (bus.miss_age),
      .valid (win_valid),
      .grant (grant)
   );

   always_comb begin
      win_age = '0;
      win_cp  = '0;
      win_pc  = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant[i]) begin
            win_age = bus.miss_age[i];
            win_cp  = bus.miss_cp[i];
            win_pc  = bus.miss_pc[i];
         end
      end
   end

   // Outside IDLE only a strictly older miss preempts; younger ones get flushed.
   assign age_diff = win_age - age_q;
   assign take     = win_valid && (state == BS_IDLE || age_diff[AGE_W-1]);
   assign expire   = (state == BS_CHKPT_RESTORE) && !bus.restore_ack && (wdog == TMO_L);

   always_comb begin
      state_nx = state;
      if (take) begin
         state_nx = BS_CHKPT_RESTORE;
      end else begin
         case (state)
            BS_IDLE:           state_nx = BS_IDLE;
            BS_CHKPT_RESTORE:  if (bus.restore_ack || wdog == TMO_L) state_nx = BS_CHKPT_RESTORED;
            BS_CHKPT_RESTORED: state_nx = BS_CAPTURE_MISSPC;
            BS_CAPTURE_MISSPC: state_nx = BS_DONE;
            BS_DONE:           state_nx = BS_DONE2;
            BS_DONE2:          state_nx = BS_IDLE;
            default:           state_nx = BS_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= BS_IDLE;
         age_q      <= '0;
         cp_q       <= '0;
         pc_q       <= RST_MISSPC;
         misspc     <= RST_MISSPC;
         branchmiss <= 1'b0;
         wdog       <= '0;
         tmo_err    <= 1'b0;
      end else begin
         state      <= state_nx;
         branchmiss <= take;
         if (take) begin
            age_q <= win_age;
            cp_q  <= win_cp;
            pc_q  <= win_pc;
         end
         if (take || state != BS_CHKPT_RESTORE) wdog <= '0;
         else                                   wdog <= wdog + 6'd1;
         if (!take && expire) tmo_err <= 1'b1;
         if (!take && state == BS_CAPTURE_MISSPC) misspc <= pc_q;
      end
   end

   assign branch_state    = state;
   assign bus.restore_req = (state == BS_CHKPT_RESTORE);
   assign bus.restore_cp  = cp_q;
   assign miss_age_o      = age_q;
   assign busy            = (state != BS_IDLE);

endmodule

// File: tb/tb_qupls_miss_sequencer.sv
// Directed bench for the branch-miss sequencer: arbitration, age wrap,
// preemption, watchdog, async reset and stray acks.
module tb_qupls_miss_sequencer;
   import qupls_miss_sequencer_pkg::*;

   logic           clk;
   logic           rst;
   logic           branchmiss;
   branch_state_t  bstate;
   pc_address_ex_t misspc;
   logic [7:0]     miss_age_o;
   logic           busy;
   logic           tmo_err;

   int checks   = 0;
   int failures = 0;
   int bm_cnt   = 0;

   qupls_miss_sequencer_if #(.NREQ(2), .AGE_W(8), .CP_W(4)) bus ();

   qupls_miss_sequencer #(.NREQ(2), .AGE_W(8), .CP_W(4), .TMO(63)) dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus),
      .branchmiss   (branchmiss),
      .branch_state (bstate),
      .misspc       (misspc),
      .miss_age_o   (miss_age_o),
      .busy         (busy),
      .tmo_err      (tmo_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) if (branchmiss === 1'b1) bm_cnt++;

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_miss(input int u, input logic [7:0] age, input logic [3:0] cp, input logic [31:0] pc);
      bus.miss_req[u] = 1'b1;
      bus.miss_age[u] = age;
      bus.miss_cp[u]  = cp;
      bus.miss_pc[u]  = '{bno_t: 3'd0, bno_f: 3'd0, pc: pc};
   endtask

   task automatic clear_miss;
      bus.miss_req = '0;
   endtask

   task automatic finish_seq;
      for (int i = 0; i < 30 && bstate !== BS_IDLE; i++) begin
         if (bstate === BS_CHKPT_RESTORE) bus.restore_ack = 1'b1;
         tick;
         bus.restore_ack = 1'b0;
      end
      checks++;
      if (bstate !== BS_IDLE) begin
         failures++;
         $display("FAIL finish_seq: state=%0d want IDLE", bstate);
      end
   endtask

   task automatic test_reset;
      rst = 1'b0;
      repeat (2) tick;
      checks++;
      if (bstate !== BS_IDLE || busy !== 1'b0 || branchmiss !== 1'b0 || tmo_err !== 1'b0) begin
         failures++;
         $display("FAIL reset_ctrl: state=%0d busy=%b bm=%b tmo=%b want 0 0 0 0", bstate, busy, branchmiss, tmo_err);
      end
      checks++;
      if (misspc !== RST_MISSPC || bus.restore_req !== 1'b0 || bus.restore_cp !== 4'd0 || miss_age_o !== 8'd0) begin
         failures++;
         $display("FAIL reset_data: misspc=%h rreq=%b rcp=%h age=%h want %h 0 0 0", misspc, bus.restore_req, bus.restore_cp, miss_age_o, RST_MISSPC);
      end
      #3 rst = 1'b1;
      tick;
   endtask

   task automatic test_single;
      int bm0;
      bm0 = bm_cnt;
      set_miss(0, 8'h10, 4'd3, 32'h1000);
      tick;
      clear_miss;
      checks++;
      if (bstate !== BS_CHKPT_RESTORE || bus.restore_req !== 1'b1 || bus.restore_cp !== 4'd3 || branchmiss !== 1'b1 || miss_age_o !== 8'h10 || busy !== 1'b1) begin
         failures++;
         $display("FAIL single_accept: st=%0d rreq=%b rcp=%h bm=%b age=%h busy=%b want 1 1 3 1 10 1", bstate, bus.restore_req, bus.restore_cp, branchmiss, miss_age_o, busy);
      end
      repeat (3) tick;
      checks++;
      if (bstate !== BS_CHKPT_RESTORE || branchmiss !== 1'b0) begin
         failures++;
         $display("FAIL single_wait: st=%0d bm=%b want 1 0", bstate, branchmiss);
      end
      bus.restore_ack = 1'b1;
      tick;
      bus.restore_ack = 1'b0;
      checks++;
      if (bstate !== BS_CHKPT_RESTORED || bus.restore_req !== 1'b0) begin
         failures++;
         $display("FAIL single_restored: st=%0d rreq=%b want 2 0", bstate, bus.restore_req);
      end
      tick;
      checks++;
      if (bstate !== BS_CAPTURE_MISSPC) begin
         failures++;
         $display("FAIL single_capture: st=%0d want 3", bstate);
      end
      tick;
      checks++;
      if (bstate !== BS_DONE || misspc.pc !== 32'h1000) begin
         failures++;
         $display("FAIL single_done: st=%0d pc=%h want 4 1000", bstate, misspc.pc);
      end
      tick;
      checks++;
      if (bstate !== BS_DONE2) begin
         failures++;
         $display("FAIL single_done2: st=%0d want 5", bstate);
      end
      tick;
      checks++;
      if (bstate !== BS_IDLE || busy !== 1'b0 || (bm_cnt - bm0) !== 1 || misspc.pc !== 32'h1000) begin
         failures++;
         $display("FAIL single_idle: st=%0d busy=%b pulses=%0d pc=%h want 0 0 1 1000", bstate, busy, bm_cnt - bm0, misspc.pc);
      end
   endtask

   task automatic test_simultaneous;
      set_miss(0, 8'h22, 4'd1, 32'h2000);
      set_miss(1, 8'h21, 4'd2, 32'h2100);
      tick;
      clear_miss;
      checks++;
      if (bus.restore_cp !== 4'd2 || miss_age_o !== 8'h21) begin
         failures++;
         $display("FAIL simul_older: rcp=%h age=%h want 2 21", bus.restore_cp, miss_age_o);
      end
      finish_seq;
      checks++;
      if (misspc.pc !== 32'h2100) begin
         failures++;
         $display("FAIL simul_pc: pc=%h want 2100", misspc.pc);
      end
      set_miss(0, 8'h21, 4'd5, 32'h2200);
      set_miss(1, 8'h21, 4'd6, 32'h2300);
      tick;
      clear_miss;
      checks++;
      if (bus.restore_cp !== 4'd5 || miss_age_o !== 8'h21) begin
         failures++;
         $display("FAIL simul_tie: rcp=%h age=%h want 5 21", bus.restore_cp, miss_age_o);
      end
      finish_seq;
      checks++;
      if (misspc.pc !== 32'h2200) begin
         failures++;
         $display("FAIL simul_tie_pc: pc=%h want 2200", misspc.pc);
      end
   endtask

   task automatic test_wrap;
      int bm0;
      bm0 = bm_cnt;
      set_miss(0, 8'hFE, 4'd7, 32'h3000);
      tick;
      clear_miss;
      set_miss(1, 8'h02, 4'd8, 32'h3100);
      tick;
      clear_miss;
      checks++;
      if (miss_age_o !== 8'hFE || bus.restore_cp !== 4'd7 || branchmiss !== 1'b0 || bstate !== BS_CHKPT_RESTORE) begin
         failures++;
         $display("FAIL wrap_younger: age=%h rcp=%h bm=%b st=%0d want FE 7 0 1", miss_age_o, bus.restore_cp, branchmiss, bstate);
      end
      set_miss(0, 8'hF0, 4'd9, 32'h30F0);
      tick;
      clear_miss;
      checks++;
      if (miss_age_o !== 8'hF0 || bus.restore_cp !== 4'd9 || branchmiss !== 1'b1 || bus.restore_req !== 1'b1) begin
         failures++;
         $display("FAIL wrap_preempt: age=%h rcp=%h bm=%b rreq=%b want F0 9 1 1", miss_age_o, bus.restore_cp, branchmiss, bus.restore_req);
      end
      finish_seq;
      checks++;
      if (misspc.pc !== 32'h30F0 || (bm_cnt - bm0) !== 2) begin
         failures++;
         $display("FAIL wrap_end: pc=%h pulses=%0d want 30F0 2", misspc.pc, bm_cnt - bm0);
      end
   endtask

   task automatic test_watchdog;
      set_miss(0, 8'h40, 4'd4, 32'h4000);
      tick;
      clear_miss;
      repeat (63) tick;
      checks++;
      if (bstate !== BS_CHKPT_RESTORE || tmo_err !== 1'b0) begin
         failures++;
         $display("FAIL wdog_early: st=%0d tmo=%b want 1 0", bstate, tmo_err);
      end
      tick;
      checks++;
      if (bstate !== BS_CHKPT_RESTORED || tmo_err !== 1'b1) begin
         failures++;
         $display("FAIL wdog_expire: st=%0d tmo=%b want 2 1", bstate, tmo_err);
      end
      finish_seq;
      checks++;
      if (tmo_err !== 1'b1 || misspc.pc !== 32'h4000) begin
         failures++;
         $display("FAIL wdog_sticky: tmo=%b pc=%h want 1 4000", tmo_err, misspc.pc);
      end
   endtask

   task automatic test_async_reset;
      set_miss(1, 8'h50, 4'd6, 32'h5000);
      tick;
      clear_miss;
      bus.restore_ack = 1'b1;
      tick;
      bus.restore_ack = 1'b0;
      tick;
      checks++;
      if (bstate !== BS_CAPTURE_MISSPC) begin
         failures++;
         $display("FAIL arst_setup: st=%0d want 3", bstate);
      end
      #2 rst = 1'b0;
      #1;
      checks++;
      if (bstate !== BS_IDLE || busy !== 1'b0 || tmo_err !== 1'b0 || misspc !== RST_MISSPC || bus.restore_cp !== 4'd0 || miss_age_o !== 8'd0) begin
         failures++;
         $display("FAIL arst_now: st=%0d busy=%b tmo=%b misspc=%h rcp=%h age=%h want 0 0 0 %h 0 0", bstate, busy, tmo_err, misspc, bus.restore_cp, miss_age_o, RST_MISSPC);
      end
      #2 rst = 1'b1;
      tick;
      set_miss(0, 8'h60, 4'd2, 32'h6000);
      tick;
      clear_miss;
      checks++;
      if (bstate !== BS_CHKPT_RESTORE || bus.restore_cp !== 4'd2 || branchmiss !== 1'b1) begin
         failures++;
         $display("FAIL arst_after: st=%0d rcp=%h bm=%b want 1 2 1", bstate, bus.restore_cp, branchmiss);
      end
      finish_seq;
      checks++;
      if (misspc.pc !== 32'h6000) begin
         failures++;
         $display("FAIL arst_pc: pc=%h want 6000", misspc.pc);
      end
   endtask

   task automatic test_stray_ack;
      bus.restore_ack = 1'b1;
      tick;
      bus.restore_ack = 1'b0;
      checks++;
      if (bstate !== BS_IDLE || bus.restore_req !== 1'b0 || branchmiss !== 1'b0) begin
         failures++;
         $display("FAIL stray_idle: st=%0d rreq=%b bm=%b want 0 0 0", bstate, bus.restore_req, branchmiss);
      end
      set_miss(0, 8'h70, 4'd1, 32'h7000);
      tick;
      clear_miss;
      bus.restore_ack = 1'b1;
      tick;
      bus.restore_ack = 1'b0;
      repeat (2) tick;
      checks++;
      if (bstate !== BS_DONE) begin
         failures++;
         $display("FAIL stray_setup: st=%0d want 4", bstate);
      end
      bus.restore_ack = 1'b1;
      tick;
      bus.restore_ack = 1'b0;
      checks++;
      if (bstate !== BS_DONE2 || bus.restore_req !== 1'b0) begin
         failures++;
         $display("FAIL stray_done: st=%0d rreq=%b want 5 0", bstate, bus.restore_req);
      end
      tick;
      checks++;
      if (bstate !== BS_IDLE || misspc.pc !== 32'h7000) begin
         failures++;
         $display("FAIL stray_end: st=%0d pc=%h want 0 7000", bstate, misspc.pc);
      end
   endtask

   initial begin
      rst             = 1'b0;
      bus.miss_req    = '0;
      bus.miss_age    = '0;
      bus.miss_cp     = '0;
      bus.miss_pc     = '0;
      bus.restore_ack = 1'b0;
      test_reset;
      test_single;
      test_simultaneous;
      test_wrap;
      test_watchdog;
      test_async_reset;
      test_stray_ack;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
